uart_tx: RTL

//  Dedicated UART transmitter: serialises bytes from a valid/ready source onto the tx line.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_tx_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame state encoding and baud timing helpers.
// The receive path imports the same package so both sides agree on timing.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_e;

    function automatic int bitPeriod(input int clkFrequency, input int baudRate);
        return clkFrequency / baudRate;
    endfunction

    function automatic int counterWidth(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Baud tick generator: one-clock tick every BIT_PERIOD clocks, phase-aligned by restart.
// Shared with the UART receiver.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int BIT_PERIOD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = counterWidth(BIT_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Restart pins the counter to zero so the first tick lands a full bit later.
    always_comb begin
        count_d = count_q + 1'b1;
        if (restart || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    assign tick = (count_q == LAST) && !restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte source into a one-entry holding register,
// then start, data (LSB first), optional parity and stop bits on a registered tx line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 9600,
    parameter int DATA_WIDTH    = 8,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int         BIT_PERIOD = bitPeriod(CLK_FREQUENCY, BAUD_RATE);
    localparam logic [2:0] DATA_LAST  = 3'(DATA_WIDTH - 1);
    localparam logic [2:0] STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic       PARITY_POL = (PARITY_ODD != 0);

    txState_e              state_q, state_d;
    logic [DATA_WIDTH-1:0] holdData_q, holdData_d;
    logic                  holdFull_q, holdFull_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [2:0]            bitIdx_q, bitIdx_d;
    logic                  tx_q, tx_d;

    logic tick;
    logic restart;
    logic accept;
    logic dataDone;
    logic stopDone;
    logic loadHold;
    logic loadBypass;
    logic lineBit;

    uart_baud_gen #(
        .BIT_PERIOD(BIT_PERIOD)
    ) baudGen (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    assign accept   = tx_valid && !holdFull_q;
    assign dataDone = (state_q == DATA) && tick && (bitIdx_q == DATA_LAST);
    assign stopDone = (state_q == STOP) && tick && (bitIdx_q == STOP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte accepted on the very cycle the last stop bit expires chains straight into START.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (holdFull_q) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (dataDone) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (stopDone) state_d = (holdFull_q || tx_valid) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        restart    = 1'b0;
        loadHold   = 1'b0;
        loadBypass = 1'b0;
        lineBit    = 1'b1;
        case (state_q)
            IDLE: begin
                restart  = holdFull_q;
                loadHold = holdFull_q;
            end
            START:  lineBit = 1'b0;
            DATA:   lineBit = shift_q[0];
            PARITY: lineBit = parity_q;
            STOP: begin
                loadHold   = stopDone && holdFull_q;
                loadBypass = stopDone && !holdFull_q && tx_valid;
            end
            default: lineBit = 1'b1;
        endcase
    end

    // Parity is captured from the byte as it enters the shifter, before any shifting.
    always_comb begin
        holdData_d = holdData_q;
        holdFull_d = holdFull_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bitIdx_d   = bitIdx_q;
        tx_d       = lineBit;

        if (accept && !loadBypass) begin
            holdData_d = tx_data;
            holdFull_d = 1'b1;
        end

        if (loadHold) begin
            holdFull_d = 1'b0;
            shift_d    = holdData_q;
            parity_d   = ^holdData_q ^ PARITY_POL;
        end else if (loadBypass) begin
            shift_d  = tx_data;
            parity_d = ^tx_data ^ PARITY_POL;
        end else if ((state_q == DATA) && tick) begin
            shift_d = shift_q >> 1;
        end

        if (tick) begin
            if (state_d != state_q) begin
                bitIdx_d = '0;
            end else if ((state_q == DATA) || (state_q == STOP)) begin
                bitIdx_d = bitIdx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            holdData_q <= '0;
            holdFull_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bitIdx_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            holdData_q <= holdData_d;
            holdFull_q <= holdFull_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bitIdx_q   <= bitIdx_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = !holdFull_q;
    assign tx_busy  = (state_q != IDLE) || holdFull_q;

endmodule
